stack_cu_seq: RTL and testbench
===============================

Name: stack_cu_seq

Overview:
- Parametrised successor to the stack processor control unit.
- Sequences fetch, decode and execute of the stack ISA through a memory request/ready handshake.
- Drives the existing datapath selectors and register write strobes.
- New over the previous generation: tracks stack depth with overflow/underflow traps, executes ALU and jump ops, and latches illegal opcodes and halt as sticky states.

Parameters:
ADDR_W, 16, width of the address space; only used for DEPTH_W bound checks
STACK_DEPTH, 256, maximum number of stack entries before overflow trap
DEPTH_W, $clog2(STACK_DEPTH)+1, width of the depth counter

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-high reset
opcode  in  6  instruction opcode, valid while cmd register holds fetched word
mem_ready  in  1  memory completes the current request this cycle
alu_zero  in  1  registered zero flag from datapath, used by JE
mem_req  out  1  memory request, held until mem_ready
memory_w  out  1  request is a write; qualifies mem_req
cmd_w, R1_w, R2_w, SR_w, PC_w  out  1 each  single-cycle register write strobes
SR_inc, PC_inc  out  1 each  0 = increment, 1 = decrement
SR_incc, PC_incc  out  2 each  SR/PC source select (ALU, ID, SSP/EP, 0)
ALU_func  out  3  0 = R1, 1 = R2, 2 = ADD, 3 = SUB, 4 = MUL, 5 = DIV
addr_sel  out  2  0 = SR, 1 = SR-1, 2 = PC, 3 = R1
data_sel  out  2  0 = SR, 1 = PC+1, 2 = ALU, 3 = IMM
depth  out  DEPTH_W  current stack entries
halted  out  1  sticky after HLT
error  out  1  sticky trap flag
err_code  out  2  1 = illegal opcode, 2 = overflow, 3 = underflow; 0 when no error
insn_count  out  32  retired instructions (see Optional Feature)

Behaviour:
- Reset (async): every output is 0, depth = 0, state = FETCH. mem_req drops immediately, even mid-transaction.
- Handshake:
  - In a MEM state, mem_req = 1 and addr_sel, data_sel, memory_w and ALU_func stay constant until a posedge with mem_ready = 1.
  - The follow-on strobe is asserted in the next state.
  - Strobes are always exactly one cycle.
- FETCH: addr_sel = PC, mem_req. On ready: cmd_w pulse, then DECODE.
- DECODE: checks, in priority order:
  - illegal opcode;
  - pops > depth → underflow;
  - depth + net push > STACK_DEPTH → overflow.
  - Any trap → ERROR.
- PUSH (pops 0, net +1):
  - MEM write: addr = SR-1, data = IMM.
  - SR_UPD: SR_incc = ID, SR_inc = dec, SR_w.
  - PC_INC twice, skipping the immediate word.
- POP (pops 1, net -1): MEM read at SR → R1_w; SR inc → SR_w; PC_INC.
- DUP (pops 1, net +1):
  - MEM read at SR → R1_w.
  - MEM write at SR-1 with data = ALU, ALU_func = R1.
  - SR dec; PC_INC.
- ADD/SUB/MUL/DIV (pops 2, net -1):
  - MEM read SR → R2_w; SR inc.
  - MEM read SR → R1_w.
  - MEM write at SR with data = ALU, ALU_func = 2 + opcode[1:0].
  - PC_INC.
- JMP (pops 1, net -1): read SR → R1_w; SR inc; PC_incc = ALU, ALU_func = R1, PC_w.
- JE (pops 1, net -1): as JMP, but if alu_zero = 0 it does PC_INC instead of loading PC.
- PC_INC: PC_incc = ID, PC_inc = inc, PC_w pulse. Returns to FETCH when the instruction is complete.
- HLT: HALT, halted = 1, no further requests until reset.
- Illegal opcodes (SWAP, MOV, MSR, PSR, PPC, WINT and unassigned codes): ERROR.
- ERROR: error = 1, err_code latched, no requests until reset.
- depth updates in the same cycle as the SR_w strobe. It never wraps, because traps prevent it.
- mem_ready is ignored outside MEM states.

Optional Feature:
- Macro: STACK_CU_INSN_COUNT_EN.
- Defined: insn_count increments by 1 on each return to FETCH from PC_INC or a jump load. It saturates at 2^32-1 and is reset to 0.
- Undefined: insn_count is tied to 0 and no counter logic is generated.

Decomposition:
- Package ssp_pkg holds:
  - opcode constants;
  - addr_sel, data_sel, SR/PC source and ALU_func encodings;
  - state enum;
  - err_code values;
  - per-opcode pops/net-push table function.
- Sub-module stack_depth_tracker: depth counter plus overflow/underflow compare, parametrised by STACK_DEPTH.

Test Plan:
- PUSH 0x0005, mem_ready high every cycle → one SR_w dec, two PC_w, depth 0→1, insn_count 1.
- PUSH, PUSH, ADD → ALU_func = 2 on the write, final depth 1, SR_w pulses: dec, dec, inc.
- POP with depth 0 → ERROR, error = 1, err_code = 3, mem_req stays 0 afterwards.
- STACK_DEPTH = 4, five PUSHes → fifth traps with err_code = 2, depth holds at 4.
- mem_ready low for 3 cycles during FETCH → mem_req and addr_sel = 2 stable, cmd_w only after ready; assert rst mid-wait → mem_req = 0 at once.
- JE with alu_zero = 0 then 1 → first does PC_INC with PC_incc = ID, second PC_w with PC_incc = ALU; then HLT → halted = 1.

Source files
------------

// File: rtl/ssp_pkg.sv
// ----------------------------------------------------------------------------
// ssp_pkg
// Shared definitions for the stack processor control unit:
//   - opcode constants
//   - datapath selector and ALU encodings
//   - FSM state codes
//   - trap codes
//   - per-opcode stack-effect table
// ----------------------------------------------------------------------------
package ssp_pkg;

   // Opcodes. ADD..DIV share opcode[5:2] so that opcode[1:0] selects the ALU op.
   localparam logic [5:0] OP_PUSH = 6'h01;
   localparam logic [5:0] OP_POP  = 6'h02;
   localparam logic [5:0] OP_DUP  = 6'h03;
   localparam logic [5:0] OP_ADD  = 6'h04;
   localparam logic [5:0] OP_SUB  = 6'h05;
   localparam logic [5:0] OP_MUL  = 6'h06;
   localparam logic [5:0] OP_DIV  = 6'h07;
   localparam logic [5:0] OP_JMP  = 6'h08;
   localparam logic [5:0] OP_JE   = 6'h09;
   localparam logic [5:0] OP_HLT  = 6'h0A;
   // Defined in the ISA but not executed by this unit (they trap).
   localparam logic [5:0] OP_SWAP = 6'h0B;
   localparam logic [5:0] OP_MOV  = 6'h0C;
   localparam logic [5:0] OP_MSR  = 6'h0D;
   localparam logic [5:0] OP_PSR  = 6'h0E;
   localparam logic [5:0] OP_PPC  = 6'h0F;
   localparam logic [5:0] OP_WINT = 6'h10;

   // addr_sel
   localparam logic [1:0] ADDR_SR    = 2'd0;
   localparam logic [1:0] ADDR_SR_M1 = 2'd1;
   localparam logic [1:0] ADDR_PC    = 2'd2;
   localparam logic [1:0] ADDR_R1    = 2'd3;

   // data_sel
   localparam logic [1:0] DATA_SR  = 2'd0;
   localparam logic [1:0] DATA_PC1 = 2'd1;
   localparam logic [1:0] DATA_ALU = 2'd2;
   localparam logic [1:0] DATA_IMM = 2'd3;

   // SR_incc / PC_incc source select
   localparam logic [1:0] SRC_ALU  = 2'd0;
   localparam logic [1:0] SRC_ID   = 2'd1;
   localparam logic [1:0] SRC_SSP  = 2'd2;
   localparam logic [1:0] SRC_ZERO = 2'd3;

   // SR_inc / PC_inc direction
   localparam logic INC_UP   = 1'b0;
   localparam logic INC_DOWN = 1'b1;

   // ALU_func
   localparam logic [2:0] ALU_R1  = 3'd0;
   localparam logic [2:0] ALU_R2  = 3'd1;
   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;
   localparam logic [2:0] ALU_MUL = 3'd4;
   localparam logic [2:0] ALU_DIV = 3'd5;

   // err_code
   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL   = 2'd1;
   localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
   localparam logic [1:0] ERR_UNDERFLOW = 2'd3;

   // FSM states
   localparam logic [4:0] S_FETCH   = 5'd0;
   localparam logic [4:0] S_CMD_W   = 5'd1;
   localparam logic [4:0] S_DECODE  = 5'd2;
   localparam logic [4:0] S_PUSH_WR = 5'd3;
   localparam logic [4:0] S_SR_DEC  = 5'd4;
   localparam logic [4:0] S_PC_INC1 = 5'd5;
   localparam logic [4:0] S_PC_INC  = 5'd6;
   localparam logic [4:0] S_RD_R1   = 5'd7;
   localparam logic [4:0] S_R1_W    = 5'd8;
   localparam logic [4:0] S_RD_R2   = 5'd9;
   localparam logic [4:0] S_R2_W    = 5'd10;
   localparam logic [4:0] S_SR_INC  = 5'd11;
   localparam logic [4:0] S_DUP_WR  = 5'd12;
   localparam logic [4:0] S_ALU_WR  = 5'd13;
   localparam logic [4:0] S_JMP     = 5'd14;
   localparam logic [4:0] S_HALT    = 5'd15;
   localparam logic [4:0] S_ERROR   = 5'd16;

   // Stack effect: net push = pushes - pops.
   typedef struct packed {
      logic       legal;
      logic [1:0] pops;
      logic [1:0] pushes;
   } op_info_t;

   // Registered control word driven onto the datapath.
   typedef struct packed {
      logic       mem_req;
      logic       memory_w;
      logic       cmd_w;
      logic       r1_w;
      logic       r2_w;
      logic       sr_w;
      logic       pc_w;
      logic       sr_inc;
      logic       pc_inc;
      logic [1:0] sr_incc;
      logic [1:0] pc_incc;
      logic [2:0] alu_func;
      logic [1:0] addr_sel;
      logic [1:0] data_sel;
   } ctrl_t;

   function automatic op_info_t op_info(input logic [5:0] op);
      op_info_t info;
      info = '{legal: 1'b1, pops: 2'd0, pushes: 2'd0};
      case (op)
         OP_PUSH:                        info.pushes = 2'd1;
         OP_POP, OP_JMP, OP_JE:          info.pops   = 2'd1;
         OP_DUP:                         begin info.pops = 2'd1; info.pushes = 2'd2; end
         OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin info.pops = 2'd2; info.pushes = 2'd1; end
         OP_HLT:                         info.legal = 1'b1;
         OP_SWAP, OP_MOV, OP_MSR,
         OP_PSR, OP_PPC, OP_WINT:        info.legal = 1'b0;
         default:                        info.legal = 1'b0;
      endcase
      return info;
   endfunction

   function automatic logic is_alu_op(input logic [5:0] op);
      return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
   endfunction

endpackage

// File: rtl/stack_depth_tracker.sv
// ----------------------------------------------------------------------------
// stack_depth_tracker
// Counts live stack entries and flags whether an instruction's stack effect
// would underflow or overflow the stack.
// Ports:
//   clk, rst       clock, async active-high reset
//   push_i, pop_i  +1 / -1 depth this cycle (mutually exclusive)
//   pops_i         entries the candidate instruction consumes
//   pushes_i       entries the candidate instruction produces
//   depth_o        current depth
//   underflow_o    pops_i > depth
//   overflow_o     depth - pops_i + pushes_i > STACK_DEPTH
// ----------------------------------------------------------------------------
module stack_depth_tracker #(
   parameter int STACK_DEPTH = 256,
   parameter int DEPTH_W     = $clog2(STACK_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [1:0]         pops_i,
   input  logic [1:0]         pushes_i,
   output logic [DEPTH_W-1:0] depth_o,
   output logic               underflow_o,
   output logic               overflow_o
);

   logic [DEPTH_W-1:0] depth_q, depth_d;
   // One extra bit so the compare never wraps.
   logic [DEPTH_W:0]   depth_x, after_x;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      depth_d = depth_q;
      if (push_i)     depth_d = depth_q + DEPTH_W'(1);
      else if (pop_i) depth_d = depth_q - DEPTH_W'(1);
   end

   assign depth_x     = {1'b0, depth_q};
   assign after_x     = depth_x + (DEPTH_W+1)'(pushes_i) - (DEPTH_W+1)'(pops_i);
   assign underflow_o = (DEPTH_W+1)'(pops_i) > depth_x;
   // Only meaningful when underflow_o is clear; the caller gives underflow priority.
   assign overflow_o  = after_x > (DEPTH_W+1)'(STACK_DEPTH);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) depth_q <= '0;
      else     depth_q <= depth_d;
   end

   assign depth_o = depth_q;

endmodule

// File: rtl/stack_cu_seq.sv
// ----------------------------------------------------------------------------
// stack_cu_seq
// Control unit for the stack processor: sequences fetch / decode / execute
// over a mem_req / mem_ready handshake and drives the datapath selectors and
// register write strobes. Traps on illegal opcodes and stack over/underflow.
// Optional macro STACK_CU_INSN_COUNT_EN: enables the saturating retired
// instruction counter on insn_count (tied to 0 otherwise).
// Ports:
//   clk, rst                        clock, async active-high reset
//   opcode                          fetched opcode (valid after cmd_w)
//   mem_ready, alu_zero             memory completion, datapath zero flag
//   mem_req, memory_w               memory request / write qualifier
//   cmd_w, R1_w, R2_w, SR_w, PC_w   one-cycle register write strobes
//   SR_inc, PC_inc                  0 = increment, 1 = decrement
//   SR_incc, PC_incc                SR/PC source select
//   ALU_func, addr_sel, data_sel    datapath selectors
//   depth, halted, error, err_code  stack depth and sticky status
//   insn_count                      retired instructions
// ----------------------------------------------------------------------------
module stack_cu_seq
   import ssp_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int STACK_DEPTH = 256,
   parameter int DEPTH_W     = $clog2(STACK_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   input  logic               alu_zero,
   output logic               mem_req,
   output logic               memory_w,
   output logic               cmd_w,
   output logic               R1_w,
   output logic               R2_w,
   output logic               SR_w,
   output logic               PC_w,
   output logic               SR_inc,
   output logic               PC_inc,
   output logic [1:0]         SR_incc,
   output logic [1:0]         PC_incc,
   output logic [2:0]         ALU_func,
   output logic [1:0]         addr_sel,
   output logic [1:0]         data_sel,
   output logic [DEPTH_W-1:0] depth,
   output logic               halted,
   output logic               error,
   output logic [1:0]         err_code,
   output logic [31:0]        insn_count
);

   // The depth counter must fit the address space and hold STACK_DEPTH.
   if ((DEPTH_W > ADDR_W) || (STACK_DEPTH >= (1 << DEPTH_W))) begin : g_cfg_check
      $error("stack_cu_seq: DEPTH_W does not fit STACK_DEPTH / ADDR_W");
   end

   logic [4:0] state_q, state_d;
   logic [5:0] op_q, op_d;
   logic [1:0] err_code_q, err_code_d;
   logic       halted_q, error_q;
   ctrl_t      ctrl_q;
   op_info_t   info;
   logic       underflow, overflow, accept;

   // Control outputs are registered from the next state, so they are glitch
   // free and all zero while rst is high. A MEM state completes only once its
   // request is actually visible, which absorbs the idle cycle after reset.
   function automatic ctrl_t ctrl_for(input logic [4:0] st, input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (st)
         S_FETCH:   begin c.mem_req = 1'b1; c.addr_sel = ADDR_PC; end
         S_CMD_W:   c.cmd_w = 1'b1;
         S_PUSH_WR: begin
            c.mem_req = 1'b1; c.memory_w = 1'b1;
            c.addr_sel = ADDR_SR_M1; c.data_sel = DATA_IMM;
         end
         S_SR_DEC:  begin c.sr_w = 1'b1; c.sr_incc = SRC_ID; c.sr_inc = INC_DOWN; end
         S_SR_INC:  begin c.sr_w = 1'b1; c.sr_incc = SRC_ID; c.sr_inc = INC_UP; end
         S_PC_INC1,
         S_PC_INC:  begin c.pc_w = 1'b1; c.pc_incc = SRC_ID; c.pc_inc = INC_UP; end
         S_RD_R1,
         S_RD_R2:   begin c.mem_req = 1'b1; c.addr_sel = ADDR_SR; end
         S_R1_W:    c.r1_w = 1'b1;
         S_R2_W:    c.r2_w = 1'b1;
         S_DUP_WR:  begin
            c.mem_req = 1'b1; c.memory_w = 1'b1;
            c.addr_sel = ADDR_SR_M1; c.data_sel = DATA_ALU; c.alu_func = ALU_R1;
         end
         S_ALU_WR:  begin
            c.mem_req = 1'b1; c.memory_w = 1'b1;
            c.addr_sel = ADDR_SR; c.data_sel = DATA_ALU;
            c.alu_func = ALU_ADD + {1'b0, op[1:0]};
         end
         S_JMP:     begin c.pc_w = 1'b1; c.pc_incc = SRC_ALU; c.alu_func = ALU_R1; end
         default:   c = '0;
      endcase
      return c;
   endfunction

   assign info   = op_info(opcode);
   assign accept = ctrl_q.mem_req & mem_ready;

   stack_depth_tracker #(
      .STACK_DEPTH (STACK_DEPTH),
      .DEPTH_W     (DEPTH_W)
   ) u_depth (
      .clk         (clk),
      .rst         (rst),
      .push_i      (state_d == S_SR_DEC),
      .pop_i       (state_d == S_SR_INC),
      .pops_i      (info.pops),
      .pushes_i    (info.pushes),
      .depth_o     (depth),
      .underflow_o (underflow),
      .overflow_o  (overflow)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      err_code_d = err_code_q;
      case (state_q)
         S_FETCH:   if (accept) state_d = S_CMD_W;
         S_CMD_W:   state_d = S_DECODE;
         S_DECODE:  begin
            op_d = opcode;
            if (!info.legal)   begin state_d = S_ERROR; err_code_d = ERR_ILLEGAL;   end
            else if (underflow) begin state_d = S_ERROR; err_code_d = ERR_UNDERFLOW; end
            else if (overflow)  begin state_d = S_ERROR; err_code_d = ERR_OVERFLOW;  end
            else if (opcode == OP_HLT)  state_d = S_HALT;
            else if (opcode == OP_PUSH) state_d = S_PUSH_WR;
            else if (is_alu_op(opcode)) state_d = S_RD_R2;
            else                        state_d = S_RD_R1;
         end
         S_PUSH_WR: if (accept) state_d = S_SR_DEC;
         // PUSH takes a second PC step to skip its immediate word.
         S_SR_DEC:  state_d = (op_q == OP_PUSH) ? S_PC_INC1 : S_PC_INC;
         S_PC_INC1: state_d = S_PC_INC;
         S_PC_INC:  state_d = S_FETCH;
         S_RD_R2:   if (accept) state_d = S_R2_W;
         S_R2_W:    state_d = S_SR_INC;
         S_SR_INC:  begin
            if (is_alu_op(op_q))    state_d = S_RD_R1;
            else if (op_q == OP_JMP) state_d = S_JMP;
            else if (op_q == OP_JE)  state_d = alu_zero ? S_JMP : S_PC_INC;
            else                     state_d = S_PC_INC;
         end
         S_RD_R1:   if (accept) state_d = S_R1_W;
         S_R1_W:    begin
            if (is_alu_op(op_q))     state_d = S_ALU_WR;
            else if (op_q == OP_DUP) state_d = S_DUP_WR;
            else                     state_d = S_SR_INC;
         end
         S_DUP_WR:  if (accept) state_d = S_SR_DEC;
         S_ALU_WR:  if (accept) state_d = S_PC_INC;
         S_JMP:     state_d = S_FETCH;
         S_HALT:    state_d = S_HALT;
         S_ERROR:   state_d = S_ERROR;
         default:   state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         op_q       <= '0;
         ctrl_q     <= '0;
         halted_q   <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         ctrl_q     <= ctrl_for(state_d, op_d);
         halted_q   <= halted_q | (state_d == S_HALT);
         error_q    <= error_q | (state_d == S_ERROR);
         err_code_q <= err_code_d;
      end
   end

   assign mem_req  = ctrl_q.mem_req;
   assign memory_w = ctrl_q.memory_w;
   assign cmd_w    = ctrl_q.cmd_w;
   assign R1_w     = ctrl_q.r1_w;
   assign R2_w     = ctrl_q.r2_w;
   assign SR_w     = ctrl_q.sr_w;
   assign PC_w     = ctrl_q.pc_w;
   assign SR_inc   = ctrl_q.sr_inc;
   assign PC_inc   = ctrl_q.pc_inc;
   assign SR_incc  = ctrl_q.sr_incc;
   assign PC_incc  = ctrl_q.pc_incc;
   assign ALU_func = ctrl_q.alu_func;
   assign addr_sel = ctrl_q.addr_sel;
   assign data_sel = ctrl_q.data_sel;
   assign halted   = halted_q;
   assign error    = error_q;
   assign err_code = err_code_q;

`ifdef STACK_CU_INSN_COUNT_EN
   logic [31:0] insn_count_q;
   logic        retire;

   // An instruction retires on its last step back to FETCH.
   assign retire = ((state_q == S_PC_INC) || (state_q == S_JMP)) && (state_d == S_FETCH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                               insn_count_q <= '0;
      else if (retire && (insn_count_q != '1)) insn_count_q <= insn_count_q + 32'd1;
   end

   assign insn_count = insn_count_q;
`else
   assign insn_count = '0;
`endif

endmodule

// File: tb/tb_stack_cu_seq.sv
// ----------------------------------------------------------------------------
// tb_stack_cu_seq
// Directed bench for stack_cu_seq built with STACK_DEPTH = 4. Each table row
// is a short program; the bench plays the memory, feeds opcodes after every
// cmd_w pulse, tallies strobes and writes, and compares against hand-computed
// totals. Hand-written sequences cover reset, the FETCH stall and reset
// during an outstanding request.
// ----------------------------------------------------------------------------
module tb_stack_cu_seq;
   import ssp_pkg::*;

   localparam int SD = 4;
   localparam int DW = $clog2(SD) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [5:0]    opcode = '0;
   logic          mem_ready = 1'b1;
   logic          alu_zero = 1'b0;
   logic          mem_req, memory_w, cmd_w, R1_w, R2_w, SR_w, PC_w, SR_inc, PC_inc;
   logic [1:0]    SR_incc, PC_incc, addr_sel, data_sel, err_code;
   logic [2:0]    ALU_func;
   logic [DW-1:0] depth;
   logic          halted, error;
   logic [31:0]   insn_count;

   int checks   = 0;
   int failures = 0;

   stack_cu_seq #(.ADDR_W(16), .STACK_DEPTH(SD), .DEPTH_W(DW)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .alu_zero(alu_zero),
      .mem_req(mem_req), .memory_w(memory_w), .cmd_w(cmd_w), .R1_w(R1_w), .R2_w(R2_w),
      .SR_w(SR_w), .PC_w(PC_w), .SR_inc(SR_inc), .PC_inc(PC_inc), .SR_incc(SR_incc),
      .PC_incc(PC_incc), .ALU_func(ALU_func), .addr_sel(addr_sel), .data_sel(data_sel),
      .depth(depth), .halted(halted), .error(error), .err_code(err_code),
      .insn_count(insn_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   typedef struct {
      string      name;
      int         n;
      logic [5:0] op [5];
      logic [4:0] az;       // alu_zero per instruction slot
      int sr_dec, sr_inc, pc_id, pc_alu, r1, r2, wr, fn, ds, dp, hl, cd, rt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string nm, input int n,
                      input logic [5:0] p0, input logic [5:0] p1, input logic [5:0] p2,
                      input logic [5:0] p3, input logic [5:0] p4, input logic [4:0] az,
                      input int sr_dec, input int sr_inc, input int pc_id, input int pc_alu,
                      input int r1, input int r2, input int wr, input int fn, input int ds,
                      input int dp, input int hl, input int cd, input int rt);
      vec_t v;
      v.name = nm; v.n = n; v.az = az;
      v.op[0] = p0; v.op[1] = p1; v.op[2] = p2; v.op[3] = p3; v.op[4] = p4;
      v.sr_dec = sr_dec; v.sr_inc = sr_inc; v.pc_id = pc_id; v.pc_alu = pc_alu;
      v.r1 = r1; v.r2 = r2; v.wr = wr; v.fn = fn; v.ds = ds;
      v.dp = dp; v.hl = hl; v.cd = cd; v.rt = rt;
      vecs.push_back(v);
   endtask

   task automatic reset_dut();
      rst = 1'b1; opcode = '0; alu_zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int fetched = 0, dec = 0, inc = 0, pid = 0, palu = 0, r1 = 0, r2 = 0;
      int wr = 0, fn = 0, ds = 0, quiet = 0;
      bit done = 1'b0;
      reset_dut();
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         @(negedge clk);
         if (cmd_w) begin
            if (fetched < v.n) begin
               opcode   = v.op[fetched];
               alu_zero = v.az[fetched];
            end
            fetched++;
         end
         if (SR_w && SR_incc == SRC_ID) begin
            if (SR_inc == INC_DOWN) dec++;
            else                    inc++;
         end
         if (PC_w && PC_incc == SRC_ID && PC_inc == INC_UP) pid++;
         if (PC_w && PC_incc == SRC_ALU && ALU_func == ALU_R1) palu++;
         if (R1_w) r1++;
         if (R2_w) r2++;
         if (mem_req && memory_w) begin wr++; fn = ALU_func; ds = data_sel; end
         if (halted || error || fetched > v.n) done = 1'b1;
         else if (fetched == v.n && mem_req && addr_sel == ADDR_PC) done = 1'b1;
      end
      check({v.name, ".done"}, done, 1);
      if (halted || error) begin
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_req) quiet++;
         end
         check({v.name, ".req_after_stop"}, quiet, 0);
      end
      check({v.name, ".sr_dec"},  dec,  v.sr_dec);
      check({v.name, ".sr_inc"},  inc,  v.sr_inc);
      check({v.name, ".pc_inc"},  pid,  v.pc_id);
      check({v.name, ".pc_load"}, palu, v.pc_alu);
      check({v.name, ".r1_w"},    r1,   v.r1);
      check({v.name, ".r2_w"},    r2,   v.r2);
      check({v.name, ".writes"},  wr,   v.wr);
      check({v.name, ".alu_func"}, fn,  v.fn);
      check({v.name, ".data_sel"}, ds,  v.ds);
      check({v.name, ".depth"},   depth, v.dp);
      check({v.name, ".halted"},  halted, v.hl);
      check({v.name, ".error"},   error, (v.cd != 0) ? 1 : 0);
      check({v.name, ".err_code"}, err_code, v.cd);
`ifdef STACK_CU_INSN_COUNT_EN
      check({v.name, ".insn_count"}, insn_count, v.rt);
`else
      check({v.name, ".insn_count"}, insn_count, 0);
`endif
   endtask

   initial begin
      int  stable;
      bit  seen;

      //  name         n  ops                                        az        dec inc pcid pcalu r1 r2 wr fn ds dp hl cd rt
      add("push",      1, OP_PUSH, 6'h0, 6'h0, 6'h0, 6'h0,           5'b00000, 1, 0, 2, 0, 0, 0, 1, 0, 3, 1, 0, 0, 1);
      add("add",       3, OP_PUSH, OP_PUSH, OP_ADD, 6'h0, 6'h0,      5'b00000, 2, 1, 5, 0, 1, 1, 3, 2, 2, 1, 0, 0, 3);
      add("sub",       3, OP_PUSH, OP_PUSH, OP_SUB, 6'h0, 6'h0,      5'b00000, 2, 1, 5, 0, 1, 1, 3, 3, 2, 1, 0, 0, 3);
      add("mul",       3, OP_PUSH, OP_PUSH, OP_MUL, 6'h0, 6'h0,      5'b00000, 2, 1, 5, 0, 1, 1, 3, 4, 2, 1, 0, 0, 3);
      add("div",       3, OP_PUSH, OP_PUSH, OP_DIV, 6'h0, 6'h0,      5'b00000, 2, 1, 5, 0, 1, 1, 3, 5, 2, 1, 0, 0, 3);
      add("pop_empty", 1, OP_POP, 6'h0, 6'h0, 6'h0, 6'h0,            5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
      add("push_pop",  2, OP_PUSH, OP_POP, 6'h0, 6'h0, 6'h0,         5'b00000, 1, 1, 3, 0, 1, 0, 1, 0, 3, 0, 0, 0, 2);
      add("dup",       2, OP_PUSH, OP_DUP, 6'h0, 6'h0, 6'h0,         5'b00000, 2, 0, 3, 0, 1, 0, 2, 0, 2, 2, 0, 0, 2);
      add("jmp",       2, OP_PUSH, OP_JMP, 6'h0, 6'h0, 6'h0,         5'b00000, 1, 1, 2, 1, 1, 0, 1, 0, 3, 0, 0, 0, 2);
      add("je_hlt",    5, OP_PUSH, OP_JE, OP_PUSH, OP_JE, OP_HLT,    5'b01000, 2, 2, 5, 1, 2, 0, 2, 0, 3, 0, 1, 0, 4);
      add("hlt",       1, OP_HLT, 6'h0, 6'h0, 6'h0, 6'h0,            5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add("swap",      1, OP_SWAP, 6'h0, 6'h0, 6'h0, 6'h0,           5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      add("op_3f",     1, 6'h3F, 6'h0, 6'h0, 6'h0, 6'h0,             5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      add("op_00",     1, 6'h00, 6'h0, 6'h0, 6'h0, 6'h0,             5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      add("add_under", 2, OP_PUSH, OP_ADD, 6'h0, 6'h0, 6'h0,         5'b00000, 1, 0, 2, 0, 0, 0, 1, 0, 3, 1, 0, 3, 1);
      add("je_empty",  1, OP_JE, 6'h0, 6'h0, 6'h0, 6'h0,             5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
      add("push_x5",   5, OP_PUSH, OP_PUSH, OP_PUSH, OP_PUSH, OP_PUSH, 5'b00000, 4, 0, 8, 0, 0, 0, 4, 0, 3, 4, 0, 2, 4);

      // Reset state while rst is held.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset.ctrl", {mem_req, memory_w, cmd_w, R1_w, R2_w, SR_w, PC_w, SR_inc, PC_inc,
                           SR_incc, PC_incc, ALU_func, addr_sel, data_sel}, 0);
      check("reset.depth",    depth, 0);
      check("reset.status",   {halted, error, err_code}, 0);
      check("reset.insn",     insn_count, 0);

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      // Overflow sequence built from the table: four pushes then DUP.
      begin
         vec_t v;
         v = vecs[vecs.size()-1];
         v.name = "dup_over"; v.op[4] = OP_DUP;
         run_vec(v);
      end

      // FETCH stall: request and address hold until mem_ready, then cmd_w.
      reset_dut();
      mem_ready = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (mem_req) seen = 1'b1;
      end
      check("stall.req_seen", seen, 1);
      stable = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (mem_req && addr_sel == ADDR_PC && !memory_w && !cmd_w) stable++;
      end
      check("stall.hold", stable, 3);
      mem_ready = 1'b1;
      @(negedge clk);
      check("stall.cmd_w", cmd_w, 1);
      check("stall.req_drop", mem_req, 0);

      // Reset asserted while a request is outstanding drops it at once.
      reset_dut();
      mem_ready = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (mem_req) seen = 1'b1;
      end
      check("midrst.req_seen", seen, 1);
      #1 rst = 1'b1;
      #1 check("midrst.req", mem_req, 0);
      check("midrst.addr_sel", addr_sel, 0);
      @(negedge clk);
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
